// File: rtl/msfsm_pkg.sv
// rtl/msfsm_pkg.sv - shared state and error-code definitions for the output sequencer
package msfsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        REQ  = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_CONFLICT = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/msfsm_cycle_timer.sv
// rtl/msfsm_cycle_timer.sv - clearable saturating up-counter with terminal flag
module msfsm_cycle_timer #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_term
);

    logic [W-1:0] r_count;

    // Clear together with increment restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= W'(i_inc);
        end else if (i_inc && !o_term) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == W'(LIMIT));

endmodule

// File: rtl/msfsm_output_sequencer.sv
// rtl/msfsm_output_sequencer.sv - glitch-filtered output commit with 4-phase req/ack and error reporting
module msfsm_output_sequencer
    import msfsm_pkg::*;
#(
    parameter int   STABLE_CYC = 2,
    parameter int   TIMEOUT    = 64,
    parameter int   CNT_W      = 8,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_P,
    input  logic             out_M,
    input  logic             ack,
    input  logic             clr_err,
    output logic             out_q,
    output logic             fire_P,
    output logic             fire_M,
    output logic             req,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic             r_out_q;
    logic             r_fire_P;
    logic             r_fire_M;
    logic             r_req;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic          w_legal;
    logic          w_illegal;
    logic          w_both;
    logic          w_commit;
    logic          w_stab_clr;
    logic          w_stab_inc;
    logic          w_stab_term;
    logic [SW-1:0] w_stab_cnt_unused;
    logic          w_tmo_clr;
    logic          w_tmo_inc;
    logic          w_tmo_term;
    logic [TW-1:0] w_tmo_cnt;
    logic          w_err_evt;
    logic [1:0]    w_err_new;

    assign w_legal   = r_out_q ? out_M : out_P;
    assign w_illegal = r_out_q ? out_P : out_M;
    assign w_both    = out_P & out_M;

    // Terminal at STABLE_CYC-1: one more legal cycle completes qualification.
    msfsm_cycle_timer #(
        .W     (SW),
        .LIMIT (STABLE_CYC - 1)
    ) u_stab_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_stab_clr),
        .i_inc   (w_stab_inc),
        .o_count (w_stab_cnt_unused),
        .o_term  (w_stab_term)
    );

    msfsm_cycle_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT)
    ) u_tmo_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_tmo_clr),
        .i_inc   (w_tmo_inc),
        .o_count (w_tmo_cnt),
        .o_term  (w_tmo_term)
    );

    always_comb begin
        w_commit   = 1'b0;
        w_stab_clr = 1'b0;
        w_stab_inc = 1'b0;
        w_tmo_inc  = 1'b0;
        w_err_evt  = 1'b0;
        w_err_new  = ERR_NONE;
        case (r_state)
            IDLE: begin
                if (w_both) begin
                    w_err_evt = 1'b1;
                    w_err_new = ERR_CONFLICT;
                end else if (w_illegal) begin
                    w_err_evt = 1'b1;
                    w_err_new = ERR_ILLEGAL;
                end else if (w_legal) begin
                    w_stab_clr = 1'b1;
                    if (STABLE_CYC == 1) begin
                        w_commit = 1'b1;
                    end else begin
                        w_stab_inc = 1'b1;
                    end
                end
            end
            QUAL: begin
                if (w_both) begin
                    w_err_evt  = 1'b1;
                    w_err_new  = ERR_CONFLICT;
                    w_stab_clr = 1'b1;
                end else if (w_legal) begin
                    if (w_stab_term) begin
                        w_commit   = 1'b1;
                        w_stab_clr = 1'b1;
                    end else begin
                        w_stab_inc = 1'b1;
                    end
                end else begin
                    w_stab_clr = 1'b1;
                end
            end
            REQ: begin
                w_tmo_inc = 1'b1;
                // Counter saturates at TIMEOUT, so this edge is seen only once per handshake.
                if (!w_tmo_term && (w_tmo_cnt == TW'(TIMEOUT - 1))) begin
                    w_err_evt = 1'b1;
                    w_err_new = ERR_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_tmo_clr = w_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_out_q    <= INIT_VAL;
            r_fire_P   <= 1'b0;
            r_fire_M   <= 1'b0;
            r_req      <= 1'b0;
            r_evt_cnt  <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_fire_P <= 1'b0;
            r_fire_M <= 1'b0;
            if (w_commit) begin
                r_out_q   <= ~r_out_q;
                r_fire_P  <= ~r_out_q;
                r_fire_M  <= r_out_q;
                r_req     <= 1'b1;
                r_evt_cnt <= r_evt_cnt + CNT_W'(1);
                r_state   <= REQ;
            end else begin
                case (r_state)
                    IDLE: if (w_legal && !w_both) r_state <= QUAL;
                    QUAL: if (!w_legal || w_both) r_state <= IDLE;
                    REQ: begin
                        if (ack) begin
                            r_req   <= 1'b0;
                            r_state <= REL;
                        end
                    end
                    REL: if (!ack) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end

            // First error wins; a same-cycle clear yields to a new error.
            if (w_err_evt && (!r_err || clr_err)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_new;
            end else if (clr_err) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign out_q    = r_out_q;
    assign fire_P   = r_fire_P;
    assign fire_M   = r_fire_M;
    assign req      = r_req;
    assign evt_cnt  = r_evt_cnt;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
